// File: rtl/tx_frame_sched_pkg.sv
// Shared definitions for the STM-1 transmit frame scheduler: geometry,
// byte-source select encoding and scheduler state encoding.
package tx_frame_sched_pkg;

  localparam int STM_NCOL   = 270;
  localparam int STM_NROW   = 9;
  localparam int STM_NSOH   = 9;
  localparam int STM_PTRROW = 3;

  localparam int ROW_W  = 4;
  localparam int COL_W  = 9;
  localparam int FCNT_W = 8;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_SOH  = 2'd1;
  localparam logic [1:0] SEL_PTR  = 2'd2;
  localparam logic [1:0] SEL_PAY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRE   = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } sched_state_e;

endpackage

// File: rtl/stm_rc_cnt.sv
// Row/column byte-slot counter for one STM-1 frame. Exposes both the current
// position and the position it will take on the next clock edge.
module stm_rc_cnt
  import tx_frame_sched_pkg::*;
#(
  parameter int NCOL = STM_NCOL,
  parameter int NROW = STM_NROW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row_nxt,
  output logic [COL_W-1:0] o_col_nxt,
  output logic             o_last,
  output logic             o_last_nxt
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NROW - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] w_row_nxt;
  logic [COL_W-1:0] w_col_nxt;

  // Clear wins over enable; exact compares keep the counters inside the frame.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (i_clr) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (i_en) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_row_nxt  = w_row_nxt;
  assign o_col_nxt  = w_col_nxt;
  assign o_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign o_last_nxt = (w_row_nxt == ROW_LAST) && (w_col_nxt == COL_LAST);

endmodule

// File: rtl/tx_frame_sched.sv
// STM-1 transmit frame scheduler: sequences byte slots, selects the byte source
// and produces the framer / BIP strobes. Every output is a register.
module tx_frame_sched
  import tx_frame_sched_pkg::*;
#(
  parameter int NCOL   = STM_NCOL,
  parameter int NROW   = STM_NROW,
  parameter int NSOH   = STM_NSOH,
  parameter int PTRROW = STM_PTRROW
) (
  input  logic              clk19,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              txsof,
  output logic              en,
  output logic [1:0]        sel,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              bipcap,
  output logic              bipclr,
  output logic              busy,
  output logic [FCNT_W-1:0] fcnt
);

  localparam logic [COL_W-1:0] SOH_COLS = COL_W'(NSOH);
  localparam logic [ROW_W-1:0] PTR_ROW  = ROW_W'(PTRROW);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic              w_run_cur;
  logic              w_run_nxt;
  logic              w_last;
  logic              w_last_nxt;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [COL_W-1:0]  w_col_nxt;
  logic [1:0]        w_sel_nxt;

  logic              r_txsof;
  logic              r_en;
  logic [1:0]        r_sel;
  logic              r_bipcap;
  logic              r_bipclr;
  logic              r_busy;
  logic [FCNT_W-1:0] r_fcnt;

  assign w_run_cur = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_run_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

  stm_rc_cnt #(
    .NCOL(NCOL),
    .NROW(NROW)
  ) u_rc_cnt (
    .clk       (clk19),
    .rst_n     (rst_n),
    .i_en      (w_run_cur),
    .i_clr     (!w_run_nxt),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_row_nxt (w_row_nxt),
    .o_col_nxt (w_col_nxt),
    .o_last    (w_last),
    .o_last_nxt(w_last_nxt)
  );

  always_ff @(posedge clk19 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The state computed here belongs to the slot opened by the coming edge, so
  // a stop seen on the edge into the frame-last slot already suppresses txsof.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_PRE;
      ST_PRE:   w_state_nxt = ST_RUN;
      ST_RUN:   if (stop) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt = SEL_IDLE;
    if (w_run_nxt) begin
      if (w_col_nxt < SOH_COLS) begin
        w_sel_nxt = (w_row_nxt == PTR_ROW) ? SEL_PTR : SEL_SOH;
      end else begin
        w_sel_nxt = SEL_PAY;
      end
    end
  end

  // Outputs are decoded from the next state/position and registered.
  always_ff @(posedge clk19 or negedge rst_n) begin
    if (!rst_n) begin
      r_txsof  <= 1'b0;
      r_en     <= 1'b0;
      r_sel    <= SEL_IDLE;
      r_bipcap <= 1'b0;
      r_bipclr <= 1'b0;
      r_busy   <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_txsof  <= (w_state_nxt == ST_PRE) || ((w_state_nxt == ST_RUN) && w_last_nxt);
      r_en     <= (w_sel_nxt == SEL_SOH);
      r_sel    <= w_sel_nxt;
      r_bipcap <= w_run_nxt && w_last_nxt;
      r_bipclr <= w_run_nxt && (w_row_nxt == '0) && (w_col_nxt == '0);
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_run_nxt && w_last_nxt) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign txsof  = r_txsof;
  assign en     = r_en;
  assign sel    = r_sel;
  assign row    = w_row;
  assign col    = w_col;
  assign bipcap = r_bipcap;
  assign bipclr = r_bipclr;
  assign busy   = r_busy;
  assign fcnt   = r_fcnt;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Self-checking bench for tx_frame_sched: a vector table for start-up, directed
// stop/reset sequences and random traffic checked against a slot-index model.
module tb_tx_frame_sched;

  localparam int NCOL   = 270;
  localparam int NROW   = 9;
  localparam int NSOH   = 9;
  localparam int PTRROW = 3;
  localparam int FLEN   = NCOL * NROW;

  localparam int S_NCOL = 12;
  localparam int S_NROW = 4;
  localparam int S_NSOH = 3;
  localparam int S_PTR  = 1;

  localparam int M_IDLE  = 0;
  localparam int M_PRE   = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  typedef struct packed {
    logic       txsof;
    logic       en;
    logic [1:0] sel;
    logic [3:0] row;
    logic [8:0] col;
    logic       bipcap;
    logic       bipclr;
    logic       busy;
    logic [7:0] fcnt;
  } outs_t;

  typedef struct {
    int ncol;
    int nrow;
    int nsoh;
    int ptr;
  } geom_t;

  typedef struct {
    int mode;
    int k;
    int fcnt;
  } model_t;

  typedef struct {
    bit    start;
    bit    stop;
    outs_t exp;
  } vec_t;

  logic       clk19 = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sStart = 1'b0;
  logic       sStop = 1'b0;

  logic       txsof, en, bipcap, bipclr, busy;
  logic [1:0] sel;
  logic [3:0] row;
  logic [8:0] col;
  logic [7:0] fcnt;

  logic       sTxsof, sEn, sBipcap, sBipclr, sBusy;
  logic [1:0] sSel;
  logic [3:0] sRow;
  logic [8:0] sCol;
  logic [7:0] sFcnt;

  int     nVec = 0;
  int     nMis = 0;
  model_t mMain;
  model_t mSmall;
  geom_t  gMain;
  geom_t  gSmall;

  always #5 clk19 = ~clk19;

  tx_frame_sched dut (
    .clk19 (clk19),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .txsof (txsof),
    .en    (en),
    .sel   (sel),
    .row   (row),
    .col   (col),
    .bipcap(bipcap),
    .bipclr(bipclr),
    .busy  (busy),
    .fcnt  (fcnt)
  );

  tx_frame_sched #(
    .NCOL  (S_NCOL),
    .NROW  (S_NROW),
    .NSOH  (S_NSOH),
    .PTRROW(S_PTR)
  ) dutSmall (
    .clk19 (clk19),
    .rst_n (rst_n),
    .start (sStart),
    .stop  (sStop),
    .txsof (sTxsof),
    .en    (sEn),
    .sel   (sSel),
    .row   (sRow),
    .col   (sCol),
    .bipcap(sBipcap),
    .bipclr(sBipclr),
    .busy  (sBusy),
    .fcnt  (sFcnt)
  );

  function automatic outs_t mk(bit tx, bit e, int s, int r, int c, bit bc, bit bl, bit by, int f);
    outs_t o;
    o.txsof  = tx;
    o.en     = e;
    o.sel    = 2'(s);
    o.row    = 4'(r);
    o.col    = 9'(c);
    o.bipcap = bc;
    o.bipclr = bl;
    o.busy   = by;
    o.fcnt   = 8'(f);
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("tx=%b en=%b sel=%0d row=%0d col=%0d bipcap=%b bipclr=%b busy=%b fcnt=%0d",
                     o.txsof, o.en, o.sel, o.row, o.col, o.bipcap, o.bipclr, o.busy, o.fcnt);
  endfunction

  function automatic model_t modelReset();
    model_t m;
    m.mode = M_IDLE;
    m.k    = 0;
    m.fcnt = 0;
    return m;
  endfunction

  // The model tracks a linear slot index within the frame; the mode returned
  // is that of the slot opened by the clock edge on which st/sp are sampled.
  function automatic model_t modelStep(model_t m, bit st, bit sp, geom_t g);
    model_t n;
    int     flen;
    n    = m;
    flen = g.ncol * g.nrow;
    case (m.mode)
      M_IDLE: if (st) begin n.mode = M_PRE; n.k = 0; end
      M_PRE:  begin n.mode = M_RUN; n.k = 0; end
      M_RUN:  begin n.k = (m.k + 1) % flen; if (sp) n.mode = M_DRAIN; end
      default: begin
        if (m.k == flen - 1) begin n.mode = M_IDLE; n.k = 0; end
        else n.k = m.k + 1;
      end
    endcase
    if ((n.mode == M_RUN || n.mode == M_DRAIN) && n.k == flen - 1) n.fcnt = (m.fcnt + 1) % 256;
    return n;
  endfunction

  function automatic outs_t modelOut(model_t m, geom_t g);
    outs_t o;
    int    r;
    int    c;
    o      = '0;
    o.busy = (m.mode != M_IDLE);
    o.fcnt = 8'(m.fcnt);
    if (m.mode == M_PRE) o.txsof = 1'b1;
    if (m.mode == M_RUN || m.mode == M_DRAIN) begin
      r        = m.k / g.ncol;
      c        = m.k % g.ncol;
      o.row    = 4'(r);
      o.col    = 9'(c);
      o.sel    = (c < g.nsoh) ? ((r == g.ptr) ? 2'd2 : 2'd1) : 2'd3;
      o.en     = (o.sel == 2'd1);
      o.bipcap = (m.k == g.ncol * g.nrow - 1);
      o.bipclr = (m.k == 0);
      o.txsof  = (m.mode == M_RUN) && o.bipcap;
    end
    return o;
  endfunction

  function automatic outs_t mainOuts();
    return outs_t'({txsof, en, sel, row, col, bipcap, bipclr, busy, fcnt});
  endfunction

  function automatic outs_t smallOuts();
    return outs_t'({sTxsof, sEn, sSel, sRow, sCol, sBipcap, sBipclr, sBusy, sFcnt});
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s @%0t: got %s | want %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("[TB] FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp);
    start = st;
    stop  = sp;
    @(posedge clk19);
    #1;
    mMain  = modelStep(mMain, st, sp, gMain);
    mSmall = modelStep(mSmall, sStart, sStop, gSmall);
  endtask

  task automatic checkMain(input string name);
    checkOutput(name, mainOuts(), modelOut(mMain, gMain));
  endtask

  // Reset is asserted between clock edges so the clear is seen as asynchronous.
  task automatic doReset(input string name);
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    sStart = 1'b0;
    sStop  = 1'b0;
    #2;
    mMain  = modelReset();
    mSmall = modelReset();
    checkOutput(name, mainOuts(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput({name, "_small"}, smallOuts(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk19);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    int   cntEn, cntPtr, cntPay, cntCo, cntTx, gapBad, lastCo;
    int   nTx, nBc, wraps, maxRow, maxCol, prevF;
    bit   reached;

    gMain  = '{ncol: NCOL, nrow: NROW, nsoh: NSOH, ptr: PTRROW};
    gSmall = '{ncol: S_NCOL, nrow: S_NROW, nsoh: S_NSOH, ptr: S_PTR};
    mMain  = modelReset();
    mSmall = modelReset();

    tbl[0] = '{start: 1'b0, stop: 1'b1, exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{start: 1'b1, stop: 1'b0, exp: mk(1, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[2] = '{start: 1'b0, stop: 1'b0, exp: mk(0, 1, 1, 0, 0, 0, 1, 1, 0)};
    tbl[3] = '{start: 1'b1, stop: 1'b0, exp: mk(0, 1, 1, 0, 1, 0, 0, 1, 0)};
    tbl[4] = '{start: 1'b0, stop: 1'b0, exp: mk(0, 1, 1, 0, 2, 0, 0, 1, 0)};
    tbl[5] = '{start: 1'b0, stop: 1'b0, exp: mk(0, 1, 1, 0, 3, 0, 0, 1, 0)};

    #1;
    doReset("reset_initial");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].start, tbl[i].stop);
      checkOutput($sformatf("table[%0d]", i), mainOuts(), tbl[i].exp);
    end

    // Three uninterrupted frames.
    doReset("reset_pre_frames");
    applyStimulus(1'b1, 1'b0);
    checkMain("frames_pre");
    cntEn = 0; cntPtr = 0; cntPay = 0; cntCo = 0; cntTx = 0; gapBad = 0; lastCo = -1;
    for (int i = 0; i < 3 * FLEN; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkMain("frames_run");
      if (en) cntEn++;
      if (sel == 2'd2) cntPtr++;
      if (sel == 2'd3) cntPay++;
      if (txsof) cntTx++;
      if (txsof && bipcap) begin
        cntCo++;
        if (lastCo >= 0 && i - lastCo != FLEN) gapBad++;
        lastCo = i;
      end
    end
    checkValue("en_count_3frames", cntEn, 3 * (NROW - 1) * NSOH);
    checkValue("sel2_count_3frames", cntPtr, 3 * NSOH);
    checkValue("sel3_count_3frames", cntPay, 3 * NROW * (NCOL - NSOH));
    checkValue("txsof_bipcap_coincide", cntCo, 3);
    checkValue("txsof_count", cntTx, 3);
    checkValue("coincide_gap", gapBad, 0);
    checkValue("fcnt_after_3frames", int'(fcnt), 3);

    // Stop in mid-frame at row 4, col 100; start during drain is ignored.
    reached = 1'b0;
    for (int i = 0; i < 2 * FLEN && !reached; i++) begin
      if (mMain.mode == M_RUN && mMain.k == 4 * NCOL + 100) reached = 1'b1;
      else begin applyStimulus(1'b0, 1'b0); checkMain("pre_stop_run"); end
    end
    checkValue("reach_row4_col100", int'(reached), 1);
    checkValue("at_row4", int'(row), 4);
    applyStimulus(1'b0, 1'b1);
    checkMain("stop_pulse");
    nTx = 0; nBc = 0;
    for (int i = 0; i < 2 * FLEN && mMain.mode != M_IDLE; i++) begin
      applyStimulus(bit'(i % 2), 1'b0);
      checkMain("drain");
      if (txsof) nTx++;
      if (bipcap) begin
        nBc++;
        checkValue("drain_bipcap_col", int'(col), NCOL - 1);
      end
    end
    checkValue("drain_txsof", nTx, 0);
    checkValue("drain_bipcap", nBc, 1);
    checkValue("drain_busy_end", int'(busy), 0);
    applyStimulus(1'b0, 1'b0);
    checkMain("drain_idle");

    // Stop sampled on the edge that opens the frame-last slot.
    applyStimulus(1'b1, 1'b0);
    checkMain("last_pre");
    reached = 1'b0;
    for (int i = 0; i < 2 * FLEN && !reached; i++) begin
      if (mMain.mode == M_RUN && mMain.k == FLEN - 2) reached = 1'b1;
      else begin applyStimulus(1'b0, 1'b0); checkMain("last_run"); end
    end
    checkValue("reach_frame_last", int'(reached), 1);
    applyStimulus(1'b0, 1'b1);
    checkMain("last_slot");
    checkValue("last_bipcap", int'(bipcap), 1);
    checkValue("last_txsof", int'(txsof), 0);
    applyStimulus(1'b0, 1'b0);
    checkValue("last_then_idle_busy", int'(busy), 0);
    checkMain("last_then_idle");

    // Reset mid-frame at row 2, col 5.
    applyStimulus(1'b1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 2 * FLEN && !reached; i++) begin
      if (mMain.mode == M_RUN && mMain.k == 2 * NCOL + 5) reached = 1'b1;
      else applyStimulus(1'b0, 1'b0);
    end
    checkValue("reach_row2_col5", int'(reached), 1);
    checkValue("fcnt_before_reset", int'(fcnt), 5);
    doReset("reset_midframe");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, bit'($urandom_range(0, 1)));
      checkMain("post_reset_idle");
    end

    // 256 frames on the reduced-geometry instance to cover the fcnt wrap.
    sStart = 1'b1;
    applyStimulus(1'b0, 1'b0);
    sStart = 1'b0;
    checkOutput("wrap_pre", smallOuts(), modelOut(mSmall, gSmall));
    wraps = 0; maxRow = 0; maxCol = 0; prevF = int'(sFcnt);
    for (int i = 0; i < 256 * S_NCOL * S_NROW; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("wrap_run", smallOuts(), modelOut(mSmall, gSmall));
      if (prevF == 255 && sFcnt == 8'd0) wraps++;
      prevF = int'(sFcnt);
      if (int'(sRow) > maxRow) maxRow = int'(sRow);
      if (int'(sCol) > maxCol) maxCol = int'(sCol);
    end
    checkValue("fcnt_wraps", wraps, 1);
    checkValue("fcnt_after_256", int'(sFcnt), 0);
    checkValue("max_row", maxRow, S_NROW - 1);
    checkValue("max_col", maxCol, S_NCOL - 1);

    // Random start/stop traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      applyStimulus(bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 1499) == 0));
      checkMain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
